// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes and the default address width.
package y86_pkg;

    localparam int Y86_WIDTH = 64;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack with saturating count. Clear takes effect before
// a same-cycle push/pop so a correct-path call/ret after a redirect is kept.
module ras_stack #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  logic [WIDTH-1:0]           data,
    output logic [WIDTH-1:0]           top,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] FULL    = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] base_ptr;
    logic [PTR_W-1:0] next_ptr;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] base_cnt;
    logic [CNT_W-1:0] next_cnt;

    // ptr names the next free slot; DEPTH is a power of two so it wraps naturally
    // and a push into a full stack lands on the oldest entry.
    always_comb begin
        base_ptr = clear ? '0 : ptr;
        base_cnt = clear ? '0 : count_q;
        next_ptr = base_ptr;
        next_cnt = base_cnt;
        if (push) begin
            next_ptr = base_ptr + PTR_ONE;
            if (base_cnt != FULL) begin
                next_cnt = base_cnt + CNT_ONE;
            end
        end else if (pop && base_cnt != '0) begin
            next_ptr = base_ptr - PTR_ONE;
            next_cnt = base_cnt - CNT_ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            ptr     <= '0;
            count_q <= '0;
        end else begin
            ptr     <= next_ptr;
            count_q <= next_cnt;
        end
    end

    always_ff @(posedge clock) begin
        if (reset && push) begin
            mem[base_ptr] <= data;
        end
    end

    assign top   = mem[ptr - PTR_ONE];
    assign count = count_q;

endmodule

// File: rtl/pc_predict.sv
// Fetch-stage PC select and next-PC predictor: valC for call/jXX, RAS for ret,
// with redirects from a not-taken jXX at M or a mispredicted ret at W.
module pc_predict
    import y86_pkg::*;
#(
    parameter int               WIDTH     = Y86_WIDTH,
    parameter int               RAS_DEPTH = 8,
    parameter logic [WIDTH-1:0] RESET_PC  = '0,
    parameter bit               USE_RAS   = 1'b1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         F_stall,
    input  logic                         f_valid,
    input  logic [3:0]                   f_icode,
    input  logic [WIDTH-1:0]             f_valC,
    input  logic [WIDTH-1:0]             f_valP,
    input  logic [3:0]                   M_icode,
    input  logic                         M_Cnd,
    input  logic [WIDTH-1:0]             M_valA,
    input  logic [3:0]                   W_icode,
    input  logic [WIDTH-1:0]             W_valM,
    input  logic [WIDTH-1:0]             W_predRet,
    output logic [WIDTH-1:0]             f_pc,
    output logic [WIDTH-1:0]             f_predRet,
    output logic [WIDTH-1:0]             F_predPC,
    output logic                         mispredict_jxx,
    output logic                         mispredict_ret,
    output logic [$clog2(RAS_DEPTH):0]   ras_count
);

    logic [WIDTH-1:0] ras_top;
    logic [WIDTH-1:0] pred_pc;
    logic             ras_push;
    logic             ras_pop;
    logic             redirect;

    // The ret at W is older than the jXX at M, so it wins and the jXX is wrong-path.
    assign mispredict_ret = (W_icode == IRET) && (W_valM != W_predRet);
    assign mispredict_jxx = (M_icode == IJXX) && !M_Cnd && !mispredict_ret;
    assign redirect       = mispredict_ret || mispredict_jxx;

    always_comb begin
        f_pc = F_predPC;
        if (mispredict_ret) begin
            f_pc = W_valM;
        end else if (mispredict_jxx) begin
            f_pc = M_valA;
        end
    end

    assign f_predRet = (USE_RAS && ras_count != '0) ? ras_top : f_valP;

    always_comb begin
        pred_pc = f_valP;
        if (f_valid) begin
            case (f_icode)
                ICALL, IJXX: pred_pc = f_valC;
                IRET:        pred_pc = f_predRet;
                default:     pred_pc = f_valP;
            endcase
        end
    end

    assign ras_push = f_valid && (f_icode == ICALL) && !F_stall;
    assign ras_pop  = f_valid && (f_icode == IRET) && !F_stall;

    always_ff @(posedge clock) begin
        if (!reset) begin
            F_predPC <= RESET_PC;
        end else if (!F_stall) begin
            F_predPC <= pred_pc;
        end
    end

    ras_stack #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clock (clock),
        .reset (reset),
        .push  (ras_push),
        .pop   (ras_pop),
        .clear (redirect),
        .data  (f_valP),
        .top   (ras_top),
        .count (ras_count)
    );

endmodule

// File: tb/tb_pc_predict.sv
// Directed-vector bench for pc_predict: table of per-cycle vectors plus
// hand-written sequences for RAS overflow, stall and mid-operation reset.
module tb_pc_predict;
    import y86_pkg::*;

    localparam int W = 64;

    logic         clock = 1'b0;
    logic         reset;
    logic         F_stall;
    logic         f_valid;
    logic [3:0]   f_icode;
    logic [W-1:0] f_valC;
    logic [W-1:0] f_valP;
    logic [3:0]   M_icode;
    logic         M_Cnd;
    logic [W-1:0] M_valA;
    logic [3:0]   W_icode;
    logic [W-1:0] W_valM;
    logic [W-1:0] W_predRet;
    logic [W-1:0] f_pc;
    logic [W-1:0] f_predRet;
    logic [W-1:0] F_predPC;
    logic         mispredict_jxx;
    logic         mispredict_ret;
    logic [3:0]   ras_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    pc_predict dut (
        .clock          (clock),
        .reset          (reset),
        .F_stall        (F_stall),
        .f_valid        (f_valid),
        .f_icode        (f_icode),
        .f_valC         (f_valC),
        .f_valP         (f_valP),
        .M_icode        (M_icode),
        .M_Cnd          (M_Cnd),
        .M_valA         (M_valA),
        .W_icode        (W_icode),
        .W_valM         (W_valM),
        .W_predRet      (W_predRet),
        .f_pc           (f_pc),
        .f_predRet      (f_predRet),
        .F_predPC       (F_predPC),
        .mispredict_jxx (mispredict_jxx),
        .mispredict_ret (mispredict_ret),
        .ras_count      (ras_count)
    );

    typedef struct {
        logic         fv;
        logic [3:0]   fi;
        logic [W-1:0] vc;
        logic [W-1:0] vp;
        logic [3:0]   mi;
        logic         mc;
        logic [W-1:0] ma;
        logic [3:0]   wi;
        logic [W-1:0] wm;
        logic [W-1:0] wp;
        logic         st;
        logic [W-1:0] e_pc;
        logic [W-1:0] e_ret;
        logic         e_mj;
        logic         e_mr;
        logic [3:0]   e_cnt;
    } vec_t;

    vec_t tbl [14];

    function automatic vec_t mk(input logic fv, input logic [3:0] fi,
                                input logic [W-1:0] vc, input logic [W-1:0] vp,
                                input logic [3:0] mi, input logic mc, input logic [W-1:0] ma,
                                input logic [3:0] wi, input logic [W-1:0] wm, input logic [W-1:0] wp,
                                input logic st, input logic [W-1:0] e_pc, input logic [W-1:0] e_ret,
                                input logic e_mj, input logic e_mr, input logic [3:0] e_cnt);
        vec_t v;
        v.fv = fv; v.fi = fi; v.vc = vc; v.vp = vp;
        v.mi = mi; v.mc = mc; v.ma = ma;
        v.wi = wi; v.wm = wm; v.wp = wp; v.st = st;
        v.e_pc = e_pc; v.e_ret = e_ret; v.e_mj = e_mj; v.e_mr = e_mr; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs mid-low-phase, then compare the combinational view.
    task automatic run_vec(input vec_t v, input string name);
        f_valid   = v.fv; f_icode = v.fi; f_valC = v.vc; f_valP = v.vp;
        M_icode   = v.mi; M_Cnd = v.mc; M_valA = v.ma;
        W_icode   = v.wi; W_valM = v.wm; W_predRet = v.wp;
        F_stall   = v.st;
        #1;
        check({name, " f_pc"},      f_pc,                v.e_pc);
        check({name, " f_predRet"}, f_predRet,           v.e_ret);
        check({name, " mis_jxx"},   W'(mispredict_jxx),  W'(v.e_mj));
        check({name, " mis_ret"},   W'(mispredict_ret),  W'(v.e_mr));
        check({name, " ras_count"}, W'(ras_count),       W'(v.e_cnt));
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        logic [W-1:0] exp_pc;
        logic [W-1:0] pred;
        logic [3:0]   exp_cnt;

        //             fv  fi     valC    valP    M_i   Cnd valA    W_i   valM    predRet st  e_pc    e_ret   mj mr cnt
        tbl[0]  = mk(1, INOP,  0,      'h1,    INOP, 0,  0,      INOP, 0,      0,      0, 'h0,    'h1,    0, 0, 0);
        tbl[1]  = mk(1, INOP,  0,      'h2,    INOP, 0,  0,      INOP, 0,      0,      0, 'h1,    'h2,    0, 0, 0);
        tbl[2]  = mk(1, IJXX,  'h100,  'hB,    INOP, 0,  0,      INOP, 0,      0,      0, 'h2,    'hB,    0, 0, 0);
        tbl[3]  = mk(1, ICALL, 'h400,  'h109,  INOP, 0,  0,      INOP, 0,      0,      0, 'h100,  'h109,  0, 0, 0);
        tbl[4]  = mk(1, IRET,  0,      'h401,  INOP, 0,  0,      INOP, 0,      0,      0, 'h400,  'h109,  0, 0, 1);
        tbl[5]  = mk(1, INOP,  0,      'h10A,  INOP, 0,  0,      IRET, 'h109,  'h109,  0, 'h109,  'h10A,  0, 0, 0);
        tbl[6]  = mk(1, IJXX,  'h500,  'h113,  INOP, 0,  0,      INOP, 0,      0,      0, 'h10A,  'h113,  0, 0, 0);
        tbl[7]  = mk(1, ICALL, 'h600,  'h509,  INOP, 0,  0,      INOP, 0,      0,      0, 'h500,  'h509,  0, 0, 0);
        tbl[8]  = mk(1, ICALL, 'h700,  'h216,  IJXX, 0,  'h20D,  INOP, 0,      0,      0, 'h20D,  'h509,  1, 0, 1);
        tbl[9]  = mk(1, INOP,  0,      'h701,  INOP, 0,  0,      INOP, 0,      0,      0, 'h700,  'h216,  0, 0, 1);
        tbl[10] = mk(1, IRET,  0,      'h301,  IJXX, 0,  'h20D,  IRET, 'h300,  'h120,  0, 'h300,  'h216,  0, 1, 1);
        tbl[11] = mk(1, INOP,  0,      'h217,  IJXX, 1,  'h999,  INOP, 0,      0,      0, 'h216,  'h217,  0, 0, 0);
        tbl[12] = mk(0, ICALL, 'hAAA,  'h220,  INOP, 0,  0,      INOP, 0,      0,      0, 'h217,  'h220,  0, 0, 0);
        tbl[13] = mk(1, INOP,  0,      'h221,  INOP, 0,  0,      INOP, 0,      0,      0, 'h220,  'h221,  0, 0, 0);

        reset = 1'b0;
        run_vec(mk(1, INOP, 0, 'h1, INOP, 0, 0, INOP, 0, 0, 0, 0, 'h1, 0, 0, 0), "pre");
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 14; i++) begin
            run_vec(tbl[i], $sformatf("v%0d", i));
            step();
        end

        // Nine nested calls into a depth-8 stack, then nine returns.
        exp_pc = 'h221;
        for (int i = 0; i < 9; i++) begin
            exp_cnt = (i < 8) ? 4'(i) : 4'd8;
            run_vec(mk(1, ICALL, W'('h1000 + i * 'h10), W'('h10 + i), INOP, 0, 0, INOP, 0, 0, 0,
                       exp_pc, (i == 0) ? W'('h10) : W'('h10 + i - 1), 0, 0, exp_cnt),
                    $sformatf("call%0d", i));
            exp_pc = W'('h1000 + i * 'h10);
            step();
        end
        for (int j = 0; j < 9; j++) begin
            pred = (j < 8) ? W'('h18 - j) : exp_pc + 1;
            run_vec(mk(1, IRET, 0, exp_pc + 1, INOP, 0, 0, INOP, 0, 0, 0,
                       exp_pc, pred, 0, 0, 4'(8 - j)),
                    $sformatf("ret%0d", j));
            exp_pc = pred;
            step();
        end

        // Stalled call: PC held, no push.
        run_vec(mk(1, ICALL, 'h3000, exp_pc + 9, INOP, 0, 0, INOP, 0, 0, 1,
                   exp_pc, exp_pc + 9, 0, 0, 0), "stall");
        step();
        run_vec(mk(1, ICALL, 'h3000, exp_pc + 9, INOP, 0, 0, INOP, 0, 0, 0,
                   exp_pc, exp_pc + 9, 0, 0, 0), "post_stall");
        step();
        // Reset asserted together with a push.
        run_vec(mk(1, ICALL, 'h4000, 'h3009, INOP, 0, 0, INOP, 0, 0, 0,
                   'h3000, exp_pc + 9, 0, 0, 1), "pre_reset");
        reset = 1'b0;
        step();
        reset = 1'b1;
        run_vec(mk(1, INOP, 0, 'h1, INOP, 0, 0, INOP, 0, 0, 0,
                   'h0, 'h1, 0, 0, 0), "after_reset");
        step();
        run_vec(mk(1, INOP, 0, 'h2, INOP, 0, 0, INOP, 0, 0, 0,
                   'h1, 'h2, 0, 0, 0), "after_reset2");
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_predict.md
# pc_predict

Fetch-stage PC selection and next-PC prediction for the pipelined Y86-64 core; successor to the single-cycle PC update. Selects the fetch address each cycle from the predicted PC, a mispredicted-branch fall-through from M, or a corrected return address from W. Predicts `call`/`jXX` targets from valC and `ret` targets from a parametrised return-address stack (RAS). Signals both misprediction kinds to pipeline control.

## Interface
- `WIDTH`, 64: address width.
- `RAS_DEPTH`, 8: return-address stack entries, power of two, ≥2.
- `RESET_PC`, 0: fetch address after reset.
- `USE_RAS`, 1: 0 = `ret` predicts valP and never reads the RAS; the RAS still tracks calls.

Ports:
- `clock` in 1: sole clock, all state updates on rising edge.
- `reset` in 1: synchronous, active-low (0 = reset on next rising edge).
- `F_stall` in 1: hold F_predPC; suppress RAS push/pop.
- `f_valid` in 1: fetched instruction valid (no imem error).
- `f_icode` in 4: icode of the instruction fetched at `f_pc`.
- `f_valC` in WIDTH: constant word of the fetched instruction.
- `f_valP` in WIDTH: fall-through address of the fetched instruction.
- `M_icode` in 4, `M_Cnd` in 1, `M_valA` in WIDTH: memory-stage branch outcome and fall-through.
- `W_icode` in 4, `W_valM` in WIDTH, `W_predRet` in WIDTH: write-back return address and the target predicted for that `ret`.
- `f_pc` out WIDTH: fetch address (combinational).
- `f_predRet` out WIDTH: RAS prediction for a fetched `ret`, carried down the pipe to become `W_predRet`.
- `F_predPC` out WIDTH: predicted-PC register.
- `mispredict_jxx` out 1, `mispredict_ret` out 1: redirect indications (combinational).
- `ras_count` out $clog2(RAS_DEPTH)+1: valid RAS entries.

## Operation
- `mispredict_ret` = W_icode==IRET && W_valM!=W_predRet. `mispredict_jxx` = M_icode==IJXX && !M_Cnd && !mispredict_ret. The ret at W is older, so the jXX at M is wrong-path.
- `f_pc` priority: mispredict_ret → W_valM; mispredict_jxx → M_valA; else F_predPC.
- Prediction (next F_predPC): ICALL or IJXX → f_valC. IRET → RAS top if USE_RAS and count>0, else f_valP. Other icodes → f_valP. When f_valid=0, predict f_valP.
- `f_predRet` = the IRET prediction above, with the same empty/USE_RAS fallback. It is driven for every icode.
- RAS push: f_valid && f_icode==ICALL && !F_stall. Pushes f_valP. When full, the oldest entry is overwritten (circular pointer) and count stays RAS_DEPTH.
- RAS pop: f_valid && f_icode==IRET && !F_stall. When empty: no change, count stays 0.
- Redirect (either mispredict): RAS is cleared, because younger wrong-path instructions may have pushed or popped. The current fetch at the corrected `f_pc` is correct-path, so its push/pop applies after the clear. Clear+push gives count=1; clear+pop gives count=0. Clear happens even when F_stall=1.
- F_predPC loads the prediction when F_stall=0 and holds when F_stall=1.
- Addresses wrap modulo 2^WIDTH; no overflow detection.

## Timing
- Reset values: F_predPC=RESET_PC, ras_count=0, top pointer=0, stack contents don't-care. `f_pc` after reset = RESET_PC unless M/W inputs signal a redirect.
- Reset asserted mid-operation overrides stall, push, pop and redirect in that cycle.
- `f_pc`, `f_predRet`, mispredict outputs: zero-latency combinational from registers and inputs.
- Register and RAS updates take effect at the next rising edge. A push in cycle n is visible as RAS top in cycle n+1.
- No handshake; control guarantees F_stall=0 whenever it acts on a redirect. The block does not depend on that guarantee.

## Structure
- Shared package `y86_pkg`: icode constants (INOP…IPOPQ, including IJXX=4'h7, ICALL=4'h8, IRET=4'h9) and the default WIDTH.
- Sub-module `ras_stack`: storage array, circular top pointer, saturating count. Controls are push, pop and clear; outputs are top and count.
- Top level: select mux, predictor and F_predPC register.

## Test plan
- Reset, then release with nop fetches: f_pc=RESET_PC, then RESET_PC+1, +2, …; ras_count=0.
- call at 0x100 (valC=0x400, valP=0x109), then ret fetched at 0x400: next f_pc=0x400. f_predRet=0x109 and ras_count returns 0. W_valM=W_predRet=0x109 → no mispredict.
- RAS_DEPTH=8: 9 nested calls with valP 0x10..0x18, then 9 rets. Predictions are 0x18..0x11, then the 9th ret predicts its own valP; count saturates at 8.
- jXX predicted taken to 0x500, then M_icode=IJXX, M_Cnd=0, M_valA=0x20D: f_pc=0x20D and mispredict_jxx=1. RAS clears; with a call fetched the same cycle, count=1.
- Same cycle: W ret with W_valM=0x300≠W_predRet=0x120, and a jXX mispredict at M: f_pc=0x300, mispredict_ret=1, mispredict_jxx=0.
- F_stall=1 with call fetched: F_predPC holds and ras_count unchanged. reset=0 during a push: all state returns to its reset values.
